// File: rtl/capture_buffer_pkg.sv
// capture_buffer_pkg
//   Shared constants for the multi-channel capture buffer: the fixed
//   Avalon-MM register map, the readdata bit layout and the kinds of read
//   tracked through the read pipeline.
//   Optional build macro: TIMESTAMP_EN (see capture_buffer_mc.sv).
package capture_buffer_pkg;

  // Word addresses of the register map
  localparam int REG_POP_BASE   = 0;
  localparam int REG_COUNT_BASE = 8;
  localparam int REG_OVF        = 14;
  localparam int REG_CTRL       = 15;

  // readdata layout for POP results
  localparam int EMPTY_BIT = 30;
  localparam int TS_W      = 14;
  localparam int TS_LSB    = 16;

  localparam logic [31:0] EMPTY_WORD = 32'(1) << EMPTY_BIT;

  // What an accepted read turns into once it reaches the output stage
  typedef enum logic [1:0] {
    RD_NONE = 2'd0,   // unmapped address, returns zero
    RD_POP  = 2'd1,   // POP of a channel FIFO
    RD_REG  = 2'd2    // COUNT / OVF / EMPTY register value
  } rd_kind_e;

endpackage

// File: rtl/cb_channel_fifo.sv
// cb_channel_fifo
//   One capture channel: circular FIFO in a simple dual-port RAM with a
//   registered read port, plus read/write pointers, an occupancy count and a
//   sticky overflow flag.
//   Ports:
//     clk, reset_n   clock, asynchronous active-low reset
//     push           push strobe, push_data is the entry to store
//     pop            pop request (already decoded from the bus)
//     clear          synchronous clear of pointers, count and overflow
//     ovf_clr        write-1-to-clear of the overflow flag
//     count          stored entries, 0..DEPTH
//     empty          count == 0
//     ovf            sticky overflow flag
//     rd_data        entry read by the last accepted pop (valid the cycle after)
module cb_channel_fifo
  import capture_buffer_pkg::*;
#(
  parameter  int ENTRY_W = 8,
  parameter  int DEPTH   = 1024,
  localparam int PTR_W   = $clog2(DEPTH),
  localparam int CNT_W   = PTR_W + 1
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               push,
  input  logic [ENTRY_W-1:0] push_data,
  input  logic               pop,
  input  logic               clear,
  input  logic               ovf_clr,
  output logic [CNT_W-1:0]   count,
  output logic               empty,
  output logic               ovf,
  output logic [ENTRY_W-1:0] rd_data
);

  localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(DEPTH);

  logic [ENTRY_W-1:0] mem [DEPTH];
  logic [ENTRY_W-1:0] rd_data_q;

  logic [PTR_W-1:0] wptr_q, wptr_d;
  logic [PTR_W-1:0] rptr_q, rptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             ovf_q, ovf_d;

  logic pop_ok;
  logic push_ok;
  logic ovf_set;

  // A pop frees a slot in the same cycle, so a full FIFO still accepts a
  // push alongside a pop. Clear beats both push and pop.
  always_comb begin
    pop_ok  = pop && !clear && (count_q != '0);
    push_ok = push && !clear && ((count_q != FULL_COUNT) || pop_ok);
    ovf_set = push && !clear && !push_ok;

    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    ovf_d   = ovf_q;

    if (clear) begin
      wptr_d  = '0;
      rptr_d  = '0;
      count_d = '0;
      ovf_d   = 1'b0;
    end else begin
      // DEPTH is a power of two, so pointer wrap is natural overflow
      if (push_ok) wptr_d = wptr_q + PTR_W'(1);
      if (pop_ok)  rptr_d = rptr_q + PTR_W'(1);
      case ({push_ok, pop_ok})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
      // A fresh overflow wins over a same-cycle software clear
      if (ovf_set)      ovf_d = 1'b1;
      else if (ovf_clr) ovf_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
    end
  end

  // RAM with read-before-write: when full, a push and a pop hit the same
  // slot and the pop must see the old entry.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wptr_q] <= push_data;
    if (pop_ok)  rd_data_q   <= mem[rptr_q];
  end

  assign count   = count_q;
  assign empty   = (count_q == '0);
  assign ovf     = ovf_q;
  assign rd_data = rd_data_q;

endmodule

// File: rtl/capture_buffer_mc.sv
// capture_buffer_mc
//   Multi-channel capture buffer. Each channel records result words from a
//   switch output port into its own circular FIFO; software drains them over
//   an Avalon-MM slave with a fixed 2-cycle pipelined read latency.
//   Ports:
//     clk, reset_n          clock, asynchronous active-low reset
//     en[NUM_CH]            per-channel push strobe
//     result                packed results, channel i at [i*DATA_W +: DATA_W]
//     chipselect, read,
//     write, address,
//     writedata             Avalon-MM slave request side (no waitrequest)
//     readdata,
//     readdatavalid         Avalon-MM read response, one pulse per read
//   Register map: 0..NUM_CH-1 POP, 8..8+NUM_CH-1 COUNT, 14 OVF (W1C),
//   15 EMPTY mask on read / CLEAR mask on write.
//   Build macro TIMESTAMP_EN: stores a 14-bit free-running cycle stamp with
//   each entry and returns it in readdata[29:16] on a non-empty POP.
module capture_buffer_mc
  import capture_buffer_pkg::*;
#(
  parameter int NUM_CH = 4,
  parameter int DATA_W = 8,
  parameter int DEPTH  = 1024,
  parameter int ADDR_W = 4
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic [NUM_CH-1:0]        en,
  input  logic [NUM_CH*DATA_W-1:0] result,
  input  logic                     chipselect,
  input  logic                     read,
  input  logic                     write,
  input  logic [ADDR_W-1:0]        address,
  input  logic [31:0]              writedata,
  output logic [31:0]              readdata,
  output logic                     readdatavalid
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
`ifdef TIMESTAMP_EN
  localparam int ENTRY_W = DATA_W + TS_W;
`else
  localparam int ENTRY_W = DATA_W;
`endif

  logic rd_acc;
  logic wr_acc;

  logic [NUM_CH-1:0]  pop_req;
  logic [NUM_CH-1:0]  clear_mask;
  logic [NUM_CH-1:0]  ovf_clr_mask;
  logic [NUM_CH-1:0]  ch_empty;
  logic [NUM_CH-1:0]  ch_ovf;
  logic [CNT_W-1:0]   ch_count   [NUM_CH];
  logic [ENTRY_W-1:0] ch_rd_data [NUM_CH];

  // Read pipeline stage 1 (alongside the RAM address stage)
  logic        s1_valid_q, s1_valid_d;
  rd_kind_e    s1_kind_q,  s1_kind_d;
  logic        s1_empty_q, s1_empty_d;
  logic [2:0]  s1_ch_q,    s1_ch_d;
  logic [31:0] s1_reg_q,   s1_reg_d;

  // Read pipeline stage 2 (output register)
  logic [31:0] readdata_q, readdata_d;
  logic        readdatavalid_q, readdatavalid_d;

  logic [ENTRY_W-1:0] rd_entry;

  logic unused_wdata;
  assign unused_wdata = ^writedata[31:NUM_CH];

`ifdef TIMESTAMP_EN
  logic [TS_W-1:0] ts_q, ts_d;

  always_comb begin
    ts_d = ts_q + TS_W'(1);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) ts_q <= '0;
    else          ts_q <= ts_d;
  end
`endif

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    logic [ENTRY_W-1:0] push_data;
`ifdef TIMESTAMP_EN
    assign push_data = {ts_q, result[g*DATA_W +: DATA_W]};
`else
    assign push_data = result[g*DATA_W +: DATA_W];
`endif

    cb_channel_fifo #(
      .ENTRY_W (ENTRY_W),
      .DEPTH   (DEPTH)
    ) u_fifo (
      .clk       (clk),
      .reset_n   (reset_n),
      .push      (en[g]),
      .push_data (push_data),
      .pop       (pop_req[g]),
      .clear     (clear_mask[g]),
      .ovf_clr   (ovf_clr_mask[g]),
      .count     (ch_count[g]),
      .empty     (ch_empty[g]),
      .ovf       (ch_ovf[g]),
      .rd_data   (ch_rd_data[g])
    );
  end

  // Bus decode. Register values and POP emptiness are captured from the
  // pre-cycle state, so a same-cycle write never affects what a read sees.
  // A POP to a channel being cleared in the same cycle reports EMPTY.
  always_comb begin
    rd_acc       = chipselect && read;
    wr_acc       = chipselect && write;
    pop_req      = '0;
    clear_mask   = '0;
    ovf_clr_mask = '0;

    if (wr_acc && (address == ADDR_W'(REG_CTRL))) clear_mask   = writedata[NUM_CH-1:0];
    if (wr_acc && (address == ADDR_W'(REG_OVF)))  ovf_clr_mask = writedata[NUM_CH-1:0];

    s1_valid_d = rd_acc;
    s1_kind_d  = RD_NONE;
    s1_empty_d = 1'b0;
    s1_ch_d    = '0;
    s1_reg_d   = '0;

    for (int i = 0; i < NUM_CH; i++) begin
      if (rd_acc && (address == ADDR_W'(REG_POP_BASE + i))) begin
        pop_req[i] = 1'b1;
        s1_kind_d  = RD_POP;
        s1_ch_d    = 3'(i);
        s1_empty_d = ch_empty[i] | clear_mask[i];
      end
      if (rd_acc && (address == ADDR_W'(REG_COUNT_BASE + i))) begin
        s1_kind_d = RD_REG;
        s1_reg_d  = 32'(ch_count[i]);
      end
    end

    if (rd_acc && (address == ADDR_W'(REG_OVF))) begin
      s1_kind_d = RD_REG;
      s1_reg_d  = 32'(ch_ovf);
    end
    if (rd_acc && (address == ADDR_W'(REG_CTRL))) begin
      s1_kind_d = RD_REG;
      s1_reg_d  = 32'(ch_empty);
    end
  end

  // Output stage: the channel RAM output register is valid here, one
  // cycle after the pop was accepted.
  always_comb begin
    rd_entry = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (s1_ch_q == 3'(i)) rd_entry = ch_rd_data[i];
    end

    readdata_d      = '0;
    readdatavalid_d = s1_valid_q;

    if (s1_valid_q) begin
      case (s1_kind_q)
        RD_POP: begin
          if (s1_empty_q) begin
            readdata_d = EMPTY_WORD;
          end else begin
            readdata_d[DATA_W-1:0] = rd_entry[DATA_W-1:0];
`ifdef TIMESTAMP_EN
            readdata_d[TS_LSB +: TS_W] = rd_entry[DATA_W +: TS_W];
`endif
          end
        end
        RD_REG:  readdata_d = s1_reg_q;
        default: readdata_d = '0;
      endcase
    end
  end

  // Reset empties the pipeline, so reads in flight produce no response
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1_valid_q      <= 1'b0;
      s1_kind_q       <= RD_NONE;
      s1_empty_q      <= 1'b0;
      s1_ch_q         <= '0;
      s1_reg_q        <= '0;
      readdata_q      <= '0;
      readdatavalid_q <= 1'b0;
    end else begin
      s1_valid_q      <= s1_valid_d;
      s1_kind_q       <= s1_kind_d;
      s1_empty_q      <= s1_empty_d;
      s1_ch_q         <= s1_ch_d;
      s1_reg_q        <= s1_reg_d;
      readdata_q      <= readdata_d;
      readdatavalid_q <= readdatavalid_d;
    end
  end

  assign readdata      = readdata_q;
  assign readdatavalid = readdatavalid_q;

endmodule
